// File: rtl/rom_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared types for the ROM port arbiter: FSM state encoding, read-grant
// owner encoding and the fixed width of the HPS ioctl byte address.
// ---------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int IOCTL_AW = 27;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI,
        RD_WAIT
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_GFX,
        G_CPU
    } owner_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter_if
// Bundles the download stream, the two read requesters and the store port.
//   slave  : arbiter side (consumes requests, drives acks/data/store port)
//   master : environment side (download source, requesters, store model)
// Download : dl_active, dl_wr, dl_addr[26:0], dl_data[15:0], dl_wait
// Gfx read : gfx_req, gfx_addr[AW-1:0], gfx_ack, gfx_data[7:0]
// Cpu read : cpu_req, cpu_addr[AW-1:0], cpu_ack, cpu_data[7:0]
// Store    : mem_addr[AW-1:0], mem_we, mem_din[7:0], mem_dout[7:0]
// ---------------------------------------------------------------------------
interface rom_port_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int AW = 17
);
    logic                dl_active;
    logic                dl_wr;
    logic [IOCTL_AW-1:0] dl_addr;
    logic [15:0]         dl_data;
    logic                dl_wait;

    logic                gfx_req;
    logic [AW-1:0]       gfx_addr;
    logic                gfx_ack;
    logic [7:0]          gfx_data;

    logic                cpu_req;
    logic [AW-1:0]       cpu_addr;
    logic                cpu_ack;
    logic [7:0]          cpu_data;

    logic [AW-1:0]       mem_addr;
    logic                mem_we;
    logic [7:0]          mem_din;
    logic [7:0]          mem_dout;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        output dl_wait,
        input  gfx_req, gfx_addr,
        output gfx_ack, gfx_data,
        input  cpu_req, cpu_addr,
        output cpu_ack, cpu_data,
        output mem_addr, mem_we, mem_din,
        input  mem_dout
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        input  dl_wait,
        output gfx_req, gfx_addr,
        input  gfx_ack, gfx_data,
        output cpu_req, cpu_addr,
        input  cpu_ack, cpu_data,
        input  mem_addr, mem_we, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/rom_port_arbiter_grant.sv
// ---------------------------------------------------------------------------
// rom_arb_grant
// Read-grant decision between gfx and cpu with a starvation guard.
// gfx normally wins; after STARVE_MAX consecutive gfx grants with cpu_req
// pending, cpu wins the next grant.
// Ports:
//   clk_sys, reset : clock, async active-high reset
//   i_en           : a read grant may be issued this cycle
//   i_gfx_req      : gfx level request
//   i_cpu_req      : cpu level request
//   o_grant        : owner granted this cycle (G_NONE when none)
// ---------------------------------------------------------------------------
module rom_arb_grant
    import rom_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic   clk_sys,
    input  logic   reset,
    input  logic   i_en,
    input  logic   i_gfx_req,
    input  logic   i_cpu_req,
    output owner_t o_grant
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_starve;
    logic          w_cpu_first;

    assign w_cpu_first = (r_starve >= CW'(STARVE_MAX));

    always_comb begin
        o_grant = G_NONE;
        if (i_en) begin
            if (i_cpu_req && (w_cpu_first || !i_gfx_req)) begin
                o_grant = G_CPU;
            end else if (i_gfx_req) begin
                o_grant = G_GFX;
            end
        end
    end

    // Only counts gfx wins that happen while the cpu is actually waiting.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!i_cpu_req || o_grant == G_CPU) begin
            r_starve <= '0;
        end else if (o_grant == G_GFX) begin
            r_starve <= r_starve + CW'(1);
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
// Shares one single-port synchronous byte store between the HPS download
// writer and two readers (gfx, cpu). Each 16-bit download word becomes two
// byte writes while dl_wait stalls the HPS; reads take IDLE + RD_WAIT.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; pending write first, else present read address
// WR_LO   | write data[7:0] to addr
// WR_HI   | write data[15:8] to addr+1, clear latch and dl_wait
// RD_WAIT | store output valid; capture it and pulse owner's ack
//
// Ports:
//   clk_sys, reset : clock, async active-high reset
//   bus            : rom_port_arbiter_if.slave (download, gfx, cpu, store)
//   dl_sum[15:0]   : byte checksum of the download, only with
//                    ROM_DL_CHECKSUM_EN defined
// ---------------------------------------------------------------------------
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW         = 17,
    parameter int STARVE_MAX = 4
)
(
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_port_arbiter_if.slave    bus
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [15:0]          dl_sum
`endif
);

    state_t              r_state;
    state_t              w_state_nx;
    owner_t              r_owner;
    owner_t              w_grant;

    logic                r_pend;
    logic [IOCTL_AW-1:0] r_pend_addr;
    logic [15:0]         r_pend_data;
    logic                r_dl_wait;
    logic [7:0]          r_gfx_data;
    logic [7:0]          r_cpu_data;

    logic                w_wr_pend;
    logic                w_grant_en;
    logic                w_in_range;
    logic [AW-1:0]       w_hi_addr;
    logic [AW-1:0]       w_mem_addr;
    logic                w_mem_we;
    logic [7:0]          w_mem_din;
    logic                w_gfx_ack;
    logic                w_cpu_ack;

    // A strobe arriving this cycle counts as pending so it pre-empts a read.
    assign w_wr_pend  = r_pend | bus.dl_wr;
    assign w_grant_en = (r_state == IDLE) && !w_wr_pend && !bus.dl_active;
    assign w_in_range = ~|r_pend_addr[IOCTL_AW-1:AW];
    assign w_hi_addr  = r_pend_addr[AW-1:0] + AW'(1);

    rom_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .i_en      (w_grant_en),
        .i_gfx_req (bus.gfx_req),
        .i_cpu_req (bus.cpu_req),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= G_NONE;
        end else begin
            r_state <= w_state_nx;
            if (w_grant != G_NONE) begin
                r_owner <= w_grant;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_mem_addr = '0;
        w_mem_we   = 1'b0;
        w_mem_din  = '0;
        w_gfx_ack  = 1'b0;
        w_cpu_ack  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_pend) begin
                    w_state_nx = WR_LO;
                end else if (w_grant == G_GFX) begin
                    w_mem_addr = bus.gfx_addr;
                    w_state_nx = RD_WAIT;
                end else if (w_grant == G_CPU) begin
                    w_mem_addr = bus.cpu_addr;
                    w_state_nx = RD_WAIT;
                end
            end
            WR_LO: begin
                w_mem_addr = r_pend_addr[AW-1:0];
                w_mem_we   = w_in_range;
                w_mem_din  = r_pend_data[7:0];
                w_state_nx = WR_HI;
            end
            WR_HI: begin
                w_mem_addr = w_hi_addr;
                w_mem_we   = w_in_range;
                w_mem_din  = r_pend_data[15:8];
                w_state_nx = IDLE;
            end
            RD_WAIT: begin
                w_gfx_ack  = (r_owner == G_GFX);
                w_cpu_ack  = (r_owner == G_CPU);
                // Read finishes first; a write that arrived meanwhile goes next.
                w_state_nx = w_wr_pend ? WR_LO : IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // A strobe during WR_HI keeps the latch pending; IDLE picks it up.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_dl_wait   <= 1'b0;
        end else if (bus.dl_wr) begin
            r_pend      <= 1'b1;
            r_pend_addr <= bus.dl_addr;
            r_pend_data <= bus.dl_data;
            r_dl_wait   <= 1'b1;
        end else if (r_state == WR_HI) begin
            r_pend      <= 1'b0;
            r_dl_wait   <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_gfx_data <= '0;
            r_cpu_data <= '0;
        end else begin
            if (w_gfx_ack) begin
                r_gfx_data <= bus.mem_dout;
            end
            if (w_cpu_ack) begin
                r_cpu_data <= bus.mem_dout;
            end
        end
    end

    // During the ack cycle the register has not loaded yet, so forward the store.
    assign bus.gfx_data = w_gfx_ack ? bus.mem_dout : r_gfx_data;
    assign bus.cpu_data = w_cpu_ack ? bus.mem_dout : r_cpu_data;
    assign bus.gfx_ack  = w_gfx_ack;
    assign bus.cpu_ack  = w_cpu_ack;
    assign bus.dl_wait  = r_dl_wait;
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_we   = w_mem_we;
    assign bus.mem_din  = w_mem_din;

`ifdef ROM_DL_CHECKSUM_EN
    logic        r_dl_active_d;
    logic [15:0] r_dl_sum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl_active_d <= 1'b0;
            r_dl_sum      <= '0;
        end else begin
            r_dl_active_d <= bus.dl_active;
            if (bus.dl_active && !r_dl_active_d) begin
                r_dl_sum <= '0;
            end else if (w_mem_we) begin
                r_dl_sum <= r_dl_sum + {8'h00, w_mem_din};
            end
        end
    end

    assign dl_sum = r_dl_sum;
`endif

endmodule
